// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU op codes, forward selects,
// opcodes and the ID/EX pipeline record.
package alu_pkg;

  localparam int unsigned ALU_XLEN   = 32;
  localparam int unsigned ALU_REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [ALU_REG_AW-1:0] rd;
    logic [ALU_REG_AW-1:0] rs1;
    logic [ALU_REG_AW-1:0] rs2;
    logic [ALU_XLEN-1:0]   rd1;
    logic [ALU_XLEN-1:0]   rd2;
    logic [ALU_XLEN-1:0]   imm;
  } id_ex_t;

  // Encoding 2'b11 is not a forwarding source and falls back to the register value.
  function automatic logic [ALU_XLEN-1:0] fwd_mux(input fwd_sel_t sel,
                                                  input logic [ALU_XLEN-1:0] reg_v,
                                                  input logic [ALU_XLEN-1:0] wb_v,
                                                  input logic [ALU_XLEN-1:0] mem_v);
    case (sel)
      FWD_WB:  return wb_v;
      FWD_MEM: return mem_v;
      default: return reg_v;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID-to-EX issue bus: decode inputs, hazard controls, forwarding sources and EX outputs.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [XLEN-1:0]   id_rd1;
  logic [XLEN-1:0]   id_rd2;
  logic [XLEN-1:0]   id_imm;
  logic              stall;
  logic              flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [XLEN-1:0]   mem_result;
  logic [XLEN-1:0]   wb_result;

  logic [2:0]        Control_Line;
  logic [XLEN-1:0]   SrcA;
  logic [XLEN-1:0]   SrcB;
  logic [XLEN-1:0]   ex_store_data;
  logic              ex_valid;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_branch;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_illegal;

  modport master (
    output id_valid, id_instr, id_rd1, id_rd2, id_imm, stall, flush,
           fwd_a, fwd_b, mem_result, wb_result,
    input  Control_Line, SrcA, SrcB, ex_store_data, ex_valid, ex_reg_write,
           ex_rd, ex_rs1, ex_rs2, ex_branch, ex_mem_read, ex_mem_write, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, id_rd1, id_rd2, id_imm, stall, flush,
           fwd_a, fwd_b, mem_result, wb_result,
    output Control_Line, SrcA, SrcB, ex_store_data, ex_valid, ex_reg_write,
           ex_rd, ex_rs1, ex_rs2, ex_branch, ex_mem_read, ex_mem_write, ex_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct3/funct7[30] to ALU op and control bits.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output ctrl_t      ctrl_c_o
);

  // Classify by opcode first, then resolve the ALU op from funct3.
  always_comb begin
    ctrl_c_o = '0;
    case (opcode_i)
      OP_R, OP_I: begin
        ctrl_c_o.reg_write   = 1'b1;
        ctrl_c_o.alu_src_imm = (opcode_i == OP_I);
        case (funct3_i)
          3'b000:  ctrl_c_o.alu_op = (opcode_i == OP_R && funct7_b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl_c_o.alu_op = ALU_AND;
          3'b110:  ctrl_c_o.alu_op = ALU_OR;
          3'b010:  ctrl_c_o.alu_op = ALU_SLT;
          3'b100:  ctrl_c_o.alu_op = ALU_XOR;
          default: ctrl_c_o.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl_c_o.alu_src_imm = 1'b1;
        ctrl_c_o.mem_read    = 1'b1;
        ctrl_c_o.reg_write   = 1'b1;
      end
      OP_STORE: begin
        ctrl_c_o.alu_src_imm = 1'b1;
        ctrl_c_o.mem_write   = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3_i == 3'b000) begin
          ctrl_c_o.alu_op = ALU_SUB;
          ctrl_c_o.branch = 1'b1;
        end else begin
          ctrl_c_o.illegal = 1'b1;
        end
      end
      default: ctrl_c_o.illegal = 1'b1;
    endcase

    // An unsupported encoding must not cause any architectural side effect.
    if (ctrl_c_o.illegal) begin
      ctrl_c_o         = '0;
      ctrl_c_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the ID instruction into the ID/EX register and drives
// forwarded ALU operands into EX.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  ctrl_t                 dec_ctrl_c;
  id_ex_t                id_entry_c;
  id_ex_t                id_ex_d;
  id_ex_t                id_ex_q;
  logic [ALU_XLEN-1:0]   src_a_c;
  logic [ALU_XLEN-1:0]   store_data_c;
  logic                  unused_instr_c;

  alu_ctrl_decode u_decode (
    .opcode_i    (bus.id_instr[6:0]),
    .funct3_i    (bus.id_instr[14:12]),
    .funct7_b5_i (bus.id_instr[30]),
    .ctrl_c_o    (dec_ctrl_c)
  );

  assign unused_instr_c = ^{bus.id_instr[31], bus.id_instr[29:25]};

  // Assemble the ID/EX record for the incoming instruction; writes to x0 are dropped.
  always_comb begin
    id_entry_c       = '0;
    id_entry_c.valid = 1'b1;
    id_entry_c.ctrl  = dec_ctrl_c;
    id_entry_c.rd    = ALU_REG_AW'(bus.id_instr[11:7]);
    id_entry_c.rs1   = ALU_REG_AW'(bus.id_instr[19:15]);
    id_entry_c.rs2   = ALU_REG_AW'(bus.id_instr[24:20]);
    id_entry_c.rd1   = ALU_XLEN'(bus.id_rd1);
    id_entry_c.rd2   = ALU_XLEN'(bus.id_rd2);
    id_entry_c.imm   = ALU_XLEN'(bus.id_imm);
    if (bus.id_instr[11:7] == 5'd0) begin
      id_entry_c.ctrl.reg_write = 1'b0;
    end
  end

  // Flush beats stall; an idle ID slot becomes a bubble.
  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.flush) begin
      id_ex_d = '0;
    end else if (!bus.stall) begin
      id_ex_d = bus.id_valid ? id_entry_c : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign src_a_c      = fwd_mux(fwd_sel_t'(bus.fwd_a), id_ex_q.rd1,
                                ALU_XLEN'(bus.wb_result), ALU_XLEN'(bus.mem_result));
  assign store_data_c = fwd_mux(fwd_sel_t'(bus.fwd_b), id_ex_q.rd2,
                                ALU_XLEN'(bus.wb_result), ALU_XLEN'(bus.mem_result));

  assign bus.Control_Line  = 3'(id_ex_q.ctrl.alu_op);
  assign bus.SrcA          = XLEN'(src_a_c);
  assign bus.SrcB          = XLEN'(id_ex_q.ctrl.alu_src_imm ? id_ex_q.imm : store_data_c);
  assign bus.ex_store_data = XLEN'(store_data_c);
  assign bus.ex_valid      = id_ex_q.valid;
  assign bus.ex_reg_write  = id_ex_q.ctrl.reg_write;
  assign bus.ex_rd         = REG_AW'(id_ex_q.rd);
  assign bus.ex_rs1        = REG_AW'(id_ex_q.rs1);
  assign bus.ex_rs2        = REG_AW'(id_ex_q.rs2);
  assign bus.ex_branch     = id_ex_q.ctrl.branch;
  assign bus.ex_mem_read   = id_ex_q.ctrl.mem_read;
  assign bus.ex_mem_write  = id_ex_q.ctrl.mem_write;
  assign bus.ex_illegal    = id_ex_q.ctrl.illegal;

endmodule
